// File: rtl/keypad_ssd_scan.sv
// 4x4 keypad scanner with per-frame debounce, N-digit hex shift buffer and multiplexed SSD drive.
// Optional leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
module keypad_ssd_scan #(
  parameter int NUM_DIGITS    = 2,
  parameter int SCAN_TICKS    = 100_000,
  parameter int DEB_SCANS     = 4,
  parameter int REFRESH_TICKS = 50_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            krow,
  output logic [3:0]            kcol,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  key_valid,
  output logic [3:0]            key_code
);

  localparam int SW = $clog2(SCAN_TICKS);
  localparam int RW = $clog2(REFRESH_TICKS);
  localparam int DW = $clog2(DEB_SCANS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_CHK,
    S_HELD,
    S_RELEASE_CHK
  } deb_state_e;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [3:0]    krow_s1_q, krow_s2_q;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    kcol_q;
  logic          seen_q, seen_d, multi_q, multi_d;
  logic [3:0]    acc_code_q, acc_code_d;
  deb_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [3:0]    buf_q [NUM_DIGITS];
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0]    seg_q;
  logic [NUM_DIGITS-1:0] dig_en_q;

  logic       col_end, frame_end, ref_end, fire, blank;
  logic [3:0] zeros, col_code, f_code;
  logic [2:0] nz;
  logic [1:0] row_idx;
  logic       f_seen, f_multi, res_key, res_none;

  // Scan timing: the synchronised row is sampled on the last cycle of each column hold.
  always_comb begin
    col_end    = (scan_cnt_q == SW'(SCAN_TICKS - 1));
    frame_end  = col_end && (col_q == 2'd3);
    scan_cnt_d = col_end ? '0 : scan_cnt_q + SW'(1);
    col_d      = col_end ? col_q + 2'd1 : col_q;
  end

  always_comb begin
    zeros    = ~krow_s2_q;
    nz       = 3'(zeros[0]) + 3'(zeros[1]) + 3'(zeros[2]) + 3'(zeros[3]);
    row_idx  = zeros[0] ? 2'd0 : zeros[1] ? 2'd1 : zeros[2] ? 2'd2 : 2'd3;
    col_code = key_map(row_idx, col_q);
    f_seen   = seen_q;
    f_multi  = multi_q;
    f_code   = acc_code_q;
    if (col_end) begin
      if (nz == 3'd1 && !seen_q) begin
        f_seen = 1'b1;
        f_code = col_code;
      end else if (nz != 3'd0) begin
        f_multi = 1'b1;
      end
    end
    res_key    = f_seen && !f_multi;
    res_none   = !f_seen && !f_multi;
    seen_d     = frame_end ? 1'b0 : f_seen;
    multi_d    = frame_end ? 1'b0 : f_multi;
    acc_code_d = f_code;
  end

  // Debounce FSM, stepped only at frame boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    fire    = 1'b0;
    cnt_inc = cnt_q + DW'(1);
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (res_key) begin
            cand_d = f_code;
            if (DEB_SCANS == 1) begin
              state_d = S_HELD;
              cnt_d   = '0;
              fire    = 1'b1;
            end else begin
              state_d = S_PRESS_CHK;
              cnt_d   = DW'(1);
            end
          end
        end
        S_PRESS_CHK: begin
          if (res_key && f_code == cand_q) begin
            if (cnt_inc == DW'(DEB_SCANS)) begin
              state_d = S_HELD;
              cnt_d   = '0;
              fire    = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (res_none) begin
            if (DEB_SCANS == 1) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_RELEASE_CHK;
              cnt_d   = DW'(1);
            end
          end
        end
        default: begin
          if (res_none) begin
            if (cnt_inc == DW'(DEB_SCANS)) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    ref_end   = (ref_cnt_q == RW'(REFRESH_TICKS - 1));
    ref_cnt_d = ref_end ? '0 : ref_cnt_q + RW'(1);
    idx_d     = idx_q;
    if (ref_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

`ifdef SSD_LZ_BLANK_EN
  localparam int CW = $clog2(NUM_DIGITS + 1);
  logic [CW-1:0] lz_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_cnt_q <= '0;
    end else if (fire && lz_cnt_q != CW'(NUM_DIGITS)) begin
      lz_cnt_q <= lz_cnt_q + CW'(1);
    end
  end

  // Digit 0 always shows; higher digits blank until that many keys have arrived.
  always_comb blank = (idx_q != '0) && (int'(idx_q) >= int'(lz_cnt_q));
`else
  always_comb blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      krow_s1_q   <= 4'hF;
      krow_s2_q   <= 4'hF;
      scan_cnt_q  <= '0;
      col_q       <= 2'd0;
      kcol_q      <= 4'b1110;
      seen_q      <= 1'b0;
      multi_q     <= 1'b0;
      acc_code_q  <= 4'h0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= 4'h0;
      ref_cnt_q   <= '0;
      idx_q       <= '0;
      seg_q       <= 7'h3F;
      dig_en_q    <= ~NUM_DIGITS'(1);
    end else begin
      krow_s1_q   <= krow;
      krow_s2_q   <= krow_s1_q;
      scan_cnt_q  <= scan_cnt_d;
      col_q       <= col_d;
      kcol_q      <= ~(4'b0001 << col_d);
      seen_q      <= seen_d;
      multi_q     <= multi_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= fire;
      if (fire) begin
        key_code_q <= f_code;
        buf_q[0]   <= f_code;
        for (int i = 1; i < NUM_DIGITS; i++) buf_q[i] <= buf_q[i-1];
      end
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      seg_q       <= blank ? 7'h00 : hex_seg(buf_q[idx_q]);
      dig_en_q    <= ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  assign kcol      = kcol_q;
  assign seg       = seg_q;
  assign dig_en    = dig_en_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: doc/keypad_ssd_scan.md
# keypad_ssd_scan

Parametrised successor to the two-digit keypad/SSD top: scans a 4x4 matrix keypad, debounces and decodes one key per press, shifts accepted hex codes into an N-digit buffer, and time-multiplexes the buffer onto a seven-segment display. Sits directly behind the keypad and SSD connector pins at board top level. Also exports a one-cycle key strobe so other logic can consume keypresses.

## Interface
- NUM_DIGITS, 2: displayed digits / buffer depth, 1..8.
- SCAN_TICKS, 100_000: clk cycles each keypad column is driven, ≥4.
- DEB_SCANS, 4: consecutive identical scan frames needed to accept a press or a release, ≥1.
- REFRESH_TICKS, 50_000: clk cycles each display digit is enabled, ≥2.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- krow  in  4  keypad rows, active-low; idle 4'hF.
- kcol  out  4  keypad column drive, one-hot active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dig_en  out  NUM_DIGITS  digit enable, one-hot active-low.
- key_valid  out  1  one-cycle strobe per accepted press.
- key_code  out  4  hex code of the most recent accepted key; held between strobes.

## Operation
- krow passes through a 2-flop synchroniser before use.
- Scanner: column index c cycles 0,1,2,3,0…; kcol[c]=0, all others 1; c advances every SCAN_TICKS cycles. krow is sampled on the last cycle of each column hold.
- Frame: one pass over all 4 columns. Frame result:
  - NONE: no zero seen.
  - KEY(code): exactly one zero bit seen in exactly one column.
  - MULTI: anything else.
- Key map, row r = index of the zero krow bit, column c:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Debounce FSM, evaluated once per frame end:
  - IDLE: KEY(k) → PRESS_CHK, cnt=1, cand=k.
  - PRESS_CHK: same KEY(k) → cnt++. When cnt reaches DEB_SCANS → HELD, fire key_valid, key_code=k. Any other result → IDLE.
  - HELD: NONE → RELEASE_CHK, cnt=1. KEY or MULTI → stay.
  - RELEASE_CHK: NONE → cnt++; when cnt reaches DEB_SCANS → IDLE. KEY or MULTI → HELD.
  - DEB_SCANS=1: a single matching frame accepts the press; a single NONE frame completes the release.
- Digit buffer d[0..NUM_DIGITS-1]:
  - On key_valid: d[0]=code, d[i]=d[i-1], oldest entry discarded.
  - Reset value: all 0.
- Display mux:
  - Digit index advances every REFRESH_TICKS cycles, wrapping from NUM_DIGITS-1 to 0.
  - dig_en[i]=0 for the active index; seg shows hex of d[i].
  - Encoding 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Reset values: kcol=4'b1110; dig_en=~1 (digit 0); seg=7'h3F; key_valid=0; key_code=0; FSM=IDLE; all counters 0.

## Timing
- Scan and refresh counters are independent; both free-run from reset release.
- key_valid: one cycle after the last column sample of the accepting frame. d[0], key_code and the strobe update in the same cycle.
- seg and dig_en are registered. They reflect the buffer no later than 1 cycle after the buffer or the digit index changes.
- Input-to-accept latency: 2 sync cycles plus up to (DEB_SCANS+1)·4·SCAN_TICKS cycles.
- Only one key_valid per press, regardless of hold duration. A new press requires a completed release.
- Reset mid-operation: everything returns to reset values asynchronously. A press in progress is dropped. A key still held after reset is accepted afresh after DEB_SCANS frames.
- Counter widths are $clog2 of the respective parameter. No overflow paths.

## Configuration
- SSD_LZ_BLANK_EN defined: leading-zero blanking.
  - Tracks the number of accepted keys, saturating at NUM_DIGITS.
  - Digit i with i ≥ max(count,1) shows seg=7'h00; dig_en still scans it.
  - Digit 0 is never blanked.
- SSD_LZ_BLANK_EN undefined: every digit always shows its buffer value (0 after reset).

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_TICKS=4, DEB_SCANS=2, REFRESH_TICKS=8.
- Reset: hold rst_n=0, then release → kcol=1110, dig_en=1110, seg=3F, key_valid=0; kcol walks 1101, 1011, 0111 at 4-cycle steps.
- Key 7: drive krow=1011 while kcol=1110, hold 5 frames → exactly one key_valid, key_code=7, seg=07 on digit 0; no further strobe while held.
- Bounce: key 5 (krow=1101 during kcol=1101) for one frame, then idle → no key_valid; FSM returns to IDLE.
- Two keys: krow=1010 during kcol=1110 for 4 frames → no key_valid.
- Sequence 1,2,3,A,B, each with a full release → digits d3..d0 = 2,3,A,B, key_code=B.
  - With SSD_LZ_BLANK_EN after only key 1: digits 1–3 show seg=00.
- Reset mid-debounce: rst_n low during PRESS_CHK → immediate reset values, no strobe. Key still held after rst_n rises → strobe after 2 fresh frames.
